// File: rtl/led_blink_pkg.sv
// -----------------------------------------------------------------------------
// led_blink_pkg
//   Shared types and constants for the multi-channel LED pattern generator.
//   - mode_t       : per-channel run-time mode (OFF / ON / BLINK / ONESHOT)
//   - MODE_W       : width of the cfg_mode field
//   - DUTY_W       : width of the brightness (duty) field
//   - div_ok()     : elaboration-time sanity check of the prescaler ratio
//   No ports (package).
// -----------------------------------------------------------------------------
package led_blink_pkg;

    localparam int MODE_W = 2;
    localparam int DUTY_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    // The prescaler needs at least two sys_clk cycles per tick so that the
    // tick is a genuine one-cycle pulse rather than a constant high.
    function automatic bit div_ok(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 1'b0;
        end
        return (clk_hz / tick_hz) >= 2;
    endfunction

endpackage

// File: rtl/led_blink_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Shared prescaler. Down-counts DIV-1..0 (DIV = CLK_HZ / TICK_HZ); when the
//   count reaches 0 it reloads DIV-1 and raises tick_out for exactly one cycle
//   on the following cycle. First tick appears DIV cycles after reset release,
//   then every DIV cycles.
// Ports
//   sys_clk   in   1   system clock
//   sys_rst   in   1   synchronous reset, active-high
//   tick_out  out  1   registered one-cycle tick
// -----------------------------------------------------------------------------
module tick_gen
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick_out
);

    localparam int DIV   = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 2;
    localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);

    if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_div_check
        $error("tick_gen: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt      <= RELOAD;
            tick_out <= 1'b0;
        end else if (cnt == '0) begin
            cnt      <= RELOAD;
            tick_out <= 1'b1;
        end else begin
            cnt      <= cnt - 1'b1;
            tick_out <= 1'b0;
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// -----------------------------------------------------------------------------
// led_blink_ctrl
//   Multi-channel LED pattern generator. A shared prescaler (tick_gen) makes a
//   one-cycle tick at TICK_HZ; each of CH_NUM channels runs a tick-based
//   down-counter in its run-time mode (OFF / ON / BLINK / ONESHOT).
// Ports
//   sys_clk     in   1        system clock
//   sys_rst     in   1        synchronous reset, active-high
//   cfg_we      in   1        config write strobe
//   cfg_ch      in   CH_W     target channel; values >= CH_NUM are ignored
//   cfg_mode    in   2        00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//   cfg_period  in   PER_W    period in ticks (0 is treated as 1)
//   cfg_duty    in   4        brightness level (only with LED_BLINK_PWM_EN)
//   tick_out    out  1        prescaler tick
//   led_out     out  CH_NUM   LED drive, bit i = channel i
// Build option
//   LED_BLINK_PWM_EN : when defined, a free-running 4-bit phase counter dims
//                      each output by its channel duty (0 dark, 15 full).
//                      When undefined, cfg_duty is latched but has no effect.
// Debug
//   Each channel's full state is held in the struct g_ch[i].st_q.
// -----------------------------------------------------------------------------
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int CH_NUM  = 4,
    parameter int PER_W   = 16,
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              tick_out,
    output logic [CH_NUM-1:0] led_out
);

    if (CH_NUM < 1 || CH_NUM > 16) begin : g_ch_num_check
        $error("led_blink_ctrl: CH_NUM must be in 1..16");
    end

    if (PER_W < 1) begin : g_per_w_check
        $error("led_blink_ctrl: PER_W must be >= 1");
    end

    typedef struct packed {
        mode_t             mode;
        logic [PER_W-1:0]  per;
        logic [PER_W-1:0]  cnt;
        logic [DUTY_W-1:0] duty;
        logic              led;
    } ch_state_t;

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tick_out (tick_out)
    );

    // A zero period would make the reload value underflow, so it is
    // promoted to 1 before anything else sees it.
    logic [PER_W-1:0] per_eff;
    assign per_eff = (cfg_period == '0) ? PER_W'(1) : cfg_period;

`ifdef LED_BLINK_PWM_EN
    logic [DUTY_W-1:0] phase;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Channels
    // cfg_we is a one-cycle strobe with no ready/backpressure: any cycle
    // with cfg_we=1 is a transfer, accepted unconditionally on the next
    // edge. A write on the same edge as a tick takes priority for that
    // channel only.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        ch_state_t st_q;
        ch_state_t st_d;
        logic      wr_hit;
        logic      led_drv;

        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        // State register
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                st_q <= '0;
            end else begin
                st_q <= st_d;
            end
        end

        // Next-state logic
        always_comb begin
            st_d = st_q;
            if (wr_hit) begin
                st_d.mode = mode_t'(cfg_mode);
                st_d.per  = per_eff;
                st_d.cnt  = per_eff - 1'b1;
                st_d.duty = cfg_duty;
                st_d.led  = (mode_t'(cfg_mode) != MODE_OFF);
            end else if (tick_out) begin
                case (st_q.mode)
                    MODE_BLINK: begin
                        if (st_q.cnt == '0) begin
                            st_d.cnt = st_q.per - 1'b1;
                            st_d.led = ~st_q.led;
                        end else begin
                            st_d.cnt = st_q.cnt - 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        // Expiry drops the LED and parks the channel in OFF.
                        if (st_q.cnt == '0) begin
                            st_d.led  = 1'b0;
                            st_d.mode = MODE_OFF;
                        end else begin
                            st_d.cnt = st_q.cnt - 1'b1;
                        end
                    end
                    default: begin
                        // OFF and ON are static between writes.
                    end
                endcase
            end
        end

        // Output logic
        always_comb begin
`ifdef LED_BLINK_PWM_EN
            led_drv = st_q.led & ((st_q.duty == 4'hF) | (phase < st_q.duty));
`else
            led_drv = st_q.led;
`endif
        end

        assign led_out[i] = led_drv;
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
module tb_led_blink_ctrl;
    import led_blink_pkg::*;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DIV     = 10;
    localparam int CH_NUM  = 4;
    localparam int PER_W   = 8;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    // ---------------- DUT signals ----------------
    logic              cfg_we     = 1'b0;
    logic [1:0]        cfg_ch     = '0;
    logic [MODE_W-1:0] cfg_mode   = '0;
    logic [PER_W-1:0]  cfg_period = '0;
    logic [DUTY_W-1:0] cfg_duty   = '0;
    logic              tick_out;
    logic [CH_NUM-1:0] led_out;

    // Second instance with a non-power-of-two channel count so that an
    // out-of-range channel index is representable on cfg_ch.
    logic              cfg_we3 = 1'b0;
    logic [1:0]        cfg_ch3 = '0;
    logic              tick_out3;
    logic [2:0]        led_out3;

    led_blink_ctrl #(
        .CLK_HZ (CLK_HZ), .TICK_HZ (TICK_HZ), .CH_NUM (CH_NUM), .PER_W (PER_W)
    ) dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_mode (cfg_mode), .cfg_period (cfg_period), .cfg_duty (cfg_duty),
        .tick_out (tick_out), .led_out (led_out)
    );

    led_blink_ctrl #(
        .CLK_HZ (CLK_HZ), .TICK_HZ (TICK_HZ), .CH_NUM (3), .PER_W (PER_W)
    ) dut3 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .cfg_we (cfg_we3), .cfg_ch (cfg_ch3),
        .cfg_mode (cfg_mode), .cfg_period (cfg_period), .cfg_duty (cfg_duty),
        .tick_out (tick_out3), .led_out (led_out3)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input mode_t mode, input int period, input int duty);
        cfg_ch     = 2'(ch);
        cfg_mode   = mode;
        cfg_period = PER_W'(period);
        cfg_duty   = DUTY_W'(duty);
        cfg_we     = 1'b1;
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic cfg_write3(input int ch, input mode_t mode, input int period);
        cfg_ch3    = 2'(ch);
        cfg_mode   = mode;
        cfg_period = PER_W'(period);
        cfg_we3    = 1'b1;
        step();
        cfg_we3    = 1'b0;
    endtask

    // Advance until tick_out is high (bounded).
    task automatic wait_tick_high();
        int n;
        n = 0;
        while (tick_out !== 1'b1 && n < 2 * DIV) begin
            step();
            n++;
        end
        check("tick_wait_bound", 16'(n < 2 * DIV), 16'd1);
    endtask

    // Advance past the edge at which the channels consume the next tick.
    task automatic next_tick();
        wait_tick_high();
        step();
    endtask

    // Number of cycles until tick_out is next seen high.
    task automatic measure_gap(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick_out !== 1'b1 && n < 4 * DIV);
    endtask

    task automatic count_led3(output int hi);
        hi = 0;
        repeat (16) begin
            step();
            if (led_out[3] === 1'b1) hi++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gap;
        int hi;
        int d;

        // Reset
        step(3);
        check("rst_led", 16'(led_out), 16'h0);
        check("rst_tick", 16'(tick_out), 16'h0);
        sys_rst = 1'b0;
        measure_gap(gap);
        check("first_tick_gap", 16'(gap), 16'(DIV));
        measure_gap(gap);
        check("tick_spacing_1", 16'(gap), 16'(DIV));
        step();
        check("tick_one_cycle", 16'(tick_out), 16'h0);

        // BLINK period 3: toggles on every third tick
        cfg_write(0, MODE_BLINK, 3, 0);
        check("blink_p3_start", 16'(led_out), 16'h1);
        exp_q.push_back(16'h1);
        exp_q.push_back(16'h1);
        exp_q.push_back(16'h0);
        exp_q.push_back(16'h0);
        exp_q.push_back(16'h0);
        exp_q.push_back(16'h1);
        while (exp_q.size() > 0) begin
            next_tick();
            check("blink_p3", 16'(led_out), exp_q.pop_front());
        end

        // BLINK period 0 behaves as period 1: toggles on every tick
        cfg_write(0, MODE_BLINK, 0, 0);
        check("blink_p0_start", 16'(led_out), 16'h1);
        next_tick();
        check("blink_p0_t1", 16'(led_out), 16'h0);
        next_tick();
        check("blink_p0_t2", 16'(led_out), 16'h1);
        next_tick();
        check("blink_p0_t3", 16'(led_out), 16'h0);

        // ONESHOT period 2 on ch1 (ch0 keeps toggling every tick)
        cfg_write(1, MODE_ONESHOT, 2, 0);
        check("oneshot_start", 16'(led_out), 16'h2);
        next_tick();
        check("oneshot_t1", 16'(led_out), 16'h3);
        next_tick();
        check("oneshot_t2", 16'(led_out), 16'h0);
        next_tick();
        check("oneshot_t3", 16'(led_out), 16'h1);
        next_tick();
        check("oneshot_t4", 16'(led_out), 16'h0);

        // Rewrite ch2 in a tick cycle: write wins, ch0 still toggles
        cfg_write(2, MODE_BLINK, 1, 0);
        check("ch2_start", 16'(led_out), 16'h4);
        wait_tick_high();
        cfg_write(2, MODE_BLINK, 1, 0);
        check("rewrite_on_tick", 16'(led_out), 16'h5);
        next_tick();
        check("rewrite_next", 16'(led_out), 16'h0);
        next_tick();
        check("rewrite_next2", 16'(led_out), 16'h5);
        // Rewrite active ch2 with period 2: pattern restarts from here
        cfg_write(2, MODE_BLINK, 2, 0);
        check("restart_write", 16'(led_out), 16'h5);
        next_tick();
        check("restart_t1", 16'(led_out), 16'h4);
        next_tick();
        check("restart_t2", 16'(led_out), 16'h1);

        // Out-of-range channel index is ignored
        cfg_write3(3, MODE_ON, 5);
        check("oob_write_ignored", 16'(led_out3), 16'h0);
        cfg_write3(2, MODE_ON, 5);
        check("inrange_write3", 16'(led_out3), 16'h4);
        check("main_unaffected", 16'(led_out), 16'h1);

        // Reset in the middle of BLINK / ONESHOT
        cfg_write(1, MODE_ONESHOT, 5, 0);
        check("pre_rst_led", 16'(led_out), 16'h3);
        step(2);
        sys_rst = 1'b1;
        step();
        check("mid_rst_led", 16'(led_out), 16'h0);
        check("mid_rst_led3", 16'(led_out3), 16'h0);
        check("mid_rst_tick", 16'(tick_out), 16'h0);
        sys_rst = 1'b0;
        measure_gap(gap);
        check("rst_restart_gap", 16'(gap), 16'(DIV));
        step();
        check("post_rst_off", 16'(led_out), 16'h0);
        next_tick();
        check("post_rst_off_tick", 16'(led_out), 16'h0);

        // Duty / brightness on ch3
        cfg_write(3, MODE_ON, 1, 4);
        count_led3(hi);
`ifdef LED_BLINK_PWM_EN
        check("duty4_high_count", 16'(hi), 16'd4);
`else
        check("duty4_high_count", 16'(hi), 16'd16);
`endif
        d = $urandom_range(1, 14);
        cfg_write(3, MODE_ON, 1, d);
        count_led3(hi);
`ifdef LED_BLINK_PWM_EN
        check("duty_rand_high_count", 16'(hi), 16'(d));
`else
        check("duty_rand_high_count", 16'(hi), 16'd16);
`endif
        cfg_write(3, MODE_ON, 1, 15);
        count_led3(hi);
        check("duty15_high_count", 16'(hi), 16'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
